// File: rtl/fact_accel_pkg.sv
// Shared definitions for the queued factorial accelerator: register offsets,
// CTRL/STATUS bit positions and the engine state encoding.
package fact_accel_pkg;

  localparam int REG_NPUSH    = 'h00;
  localparam int REG_CTRL     = 'h01;
  localparam int REG_STATUS   = 'h02;
  localparam int REG_RCOUNT   = 'h03;
  localparam int REG_RES_BASE = 'h08;

  localparam int CTRL_INT_EN  = 0;
  localparam int CTRL_FLUSH   = 1;
  localparam int CTRL_ERR_CLR = 2;

  localparam int STAT_RES_VALID = 0;
  localparam int STAT_CMD_FULL  = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_ERR       = 3;
  localparam int STAT_OVF_HEAD  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_STORE = 2'd2
  } eng_state_e;

endpackage

// File: rtl/fact_fifo.sv
// Synchronous FIFO used for both the command and the result queue.
// Ports: clk, rst_n (async active-low), flush_i (synchronous empty),
//   push_i/din_i, pop_i/dout_o (head, combinational), full_o, empty_o, count_o.
// A push while full is dropped even if a pop happens on the same edge.
module fact_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [W-1:0]             din_i,
  input  logic                     pop_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (!do_push && do_pop) count_q <= count_q - 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fact_accel_queued.sv
// Queued factorial accelerator behind a simple memory-mapped byte bus.
// Operands are pushed to a command queue; the engine computes N! truncated
// to FN_W bits and pushes it to a result queue read back bytewise.
// Ports: clk, rst (async active-low), cs/readmem/writemem/address/dataIn bus
//   inputs, dataOut (tri-stated unless cs&&readmem), memDataReady (one-cycle
//   access ack), interrupt (int_en && (res_valid || err)).
// Build option: define FACT_OVF_DETECT_EN to store a per-result overflow flag
//   reported in STATUS bit4 for the head entry.
//
// state    | meaning
// ST_IDLE  | waiting for an operand and room in the result queue
// ST_MUL   | acc *= cnt, cnt-- until cnt <= 1
// ST_STORE | push acc (and overflow flag) into the result queue
module fact_accel_queued
  import fact_accel_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12,
  parameter int N_W    = 8,
  parameter int FN_W   = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              readmem,
  input  logic              writemem,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] dataIn,
  output logic [DATA_W-1:0] dataOut,
  output logic              memDataReady,
  output logic              interrupt
);
  localparam int CW        = $clog2(DEPTH) + 1;
  localparam int RES_BYTES = FN_W / 8;
`ifdef FACT_OVF_DETECT_EN
  localparam int RES_W = FN_W + 1;
`else
  localparam int RES_W = FN_W;
`endif

  eng_state_e      state_q;
  logic [FN_W-1:0] acc_q;
  logic [N_W-1:0]  cnt_q;
  logic            int_en_q, err_q;

  logic wr_en, cmd_push, ctrl_wr, flush, err_clr, res_pop;
  logic cmd_full, cmd_empty, res_full, res_empty;
  logic eng_start, res_push, busy, ovf_head;
  logic [N_W-1:0]   cmd_dout;
  logic [CW-1:0]    cmd_count, res_count;
  logic [RES_W-1:0] res_din, res_dout;
  logic [DATA_W-1:0] rdata;

  assign wr_en    = cs && writemem;
  assign cmd_push = wr_en && (address == ADDR_W'(REG_NPUSH));
  assign ctrl_wr  = wr_en && (address == ADDR_W'(REG_CTRL));
  assign res_pop  = wr_en && (address == ADDR_W'(REG_RCOUNT));
  assign flush    = ctrl_wr && dataIn[CTRL_FLUSH];
  assign err_clr  = ctrl_wr && dataIn[CTRL_ERR_CLR];

  assign eng_start = (state_q == ST_IDLE) && !cmd_empty && !res_full && !flush;
  assign res_push  = (state_q == ST_STORE) && !flush;
  assign busy      = (state_q != ST_IDLE) || (cmd_count != '0);

`ifdef FACT_OVF_DETECT_EN
  logic                ovf_q;
  logic [FN_W+N_W-1:0] prod;
  assign prod     = {{N_W{1'b0}}, acc_q} * {{FN_W{1'b0}}, cnt_q};
  assign res_din  = {ovf_q, acc_q};
  assign ovf_head = !res_empty && res_dout[FN_W];
`else
  logic [FN_W-1:0] prod;
  assign prod     = acc_q * FN_W'(cnt_q);
  assign res_din  = acc_q;
  assign ovf_head = 1'b0;
`endif

  fact_fifo #(.W(N_W), .DEPTH(DEPTH)) u_cmd_q (
    .clk(clk), .rst_n(rst), .flush_i(flush),
    .push_i(cmd_push), .din_i(dataIn[N_W-1:0]),
    .pop_i(eng_start), .dout_o(cmd_dout),
    .full_o(cmd_full), .empty_o(cmd_empty), .count_o(cmd_count)
  );

  fact_fifo #(.W(RES_W), .DEPTH(DEPTH)) u_res_q (
    .clk(clk), .rst_n(rst), .flush_i(flush),
    .push_i(res_push), .din_i(res_din),
    .pop_i(res_pop), .dout_o(res_dout),
    .full_o(res_full), .empty_o(res_empty), .count_o(res_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
`ifdef FACT_OVF_DETECT_EN
      ovf_q   <= 1'b0;
`endif
    end else if (flush) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (eng_start) begin
            state_q <= ST_MUL;
            acc_q   <= FN_W'(1);
            cnt_q   <= cmd_dout;
`ifdef FACT_OVF_DETECT_EN
            ovf_q   <= 1'b0;
`endif
          end
        end
        ST_MUL: begin
          if (cnt_q < N_W'(2)) begin
            state_q <= ST_STORE;
          end else begin
            acc_q <= prod[FN_W-1:0];
            cnt_q <= cnt_q - 1'b1;
`ifdef FACT_OVF_DETECT_EN
            if (|prod[FN_W+N_W-1:FN_W]) ovf_q <= 1'b1;
`endif
          end
        end
        ST_STORE: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      int_en_q     <= 1'b0;
      err_q        <= 1'b0;
      memDataReady <= 1'b0;
    end else begin
      memDataReady <= cs && (readmem || writemem);
      if (ctrl_wr) int_en_q <= dataIn[CTRL_INT_EN];
      // A dropped push is checked against fullness before any same-edge pop.
      if (cmd_push && cmd_full) err_q <= 1'b1;
      else if (err_clr)         err_q <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    if (address == ADDR_W'(REG_CTRL)) begin
      rdata[CTRL_INT_EN] = int_en_q;
    end else if (address == ADDR_W'(REG_STATUS)) begin
      rdata[STAT_RES_VALID] = !res_empty;
      rdata[STAT_CMD_FULL]  = cmd_full;
      rdata[STAT_BUSY]      = busy;
      rdata[STAT_ERR]       = err_q;
      rdata[STAT_OVF_HEAD]  = ovf_head;
    end else if (address == ADDR_W'(REG_RCOUNT)) begin
      rdata = DATA_W'(res_count);
    end else begin
      for (int k = 0; k < RES_BYTES; k++) begin
        if (!res_empty && (address == ADDR_W'(REG_RES_BASE + k)))
          rdata = res_dout[8*k +: 8];
      end
    end
  end

  assign dataOut   = (cs && readmem) ? rdata : 'z;
  assign interrupt = int_en_q && (!res_empty || err_q);

endmodule

// File: tb/tb_fact_accel_queued.sv
module tb_fact_accel_queued;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
  localparam int N_W    = 8;
  localparam int FN_W   = 32;
  localparam int DEPTH  = 4;
`ifdef FACT_OVF_DETECT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cs = 1'b0, readmem = 1'b0, writemem = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic [DATA_W-1:0] dataIn = '0;
  wire  [DATA_W-1:0] dataOut;
  logic memDataReady, interrupt;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int          n;
    logic [31:0] res;
    bit          ovf;
  } vec_t;
  vec_t tbl [9];

  always #5 clk = ~clk;

  fact_accel_queued #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_W(N_W), .FN_W(FN_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .cs(cs), .readmem(readmem), .writemem(writemem),
    .address(address), .dataIn(dataIn), .dataOut(dataOut),
    .memDataReady(memDataReady), .interrupt(interrupt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bus tasks start at a falling edge and return at the next falling edge.
  task automatic bus_wr(input int a, input logic [7:0] d);
    cs = 1'b1; writemem = 1'b1; readmem = 1'b0;
    address = ADDR_W'(a); dataIn = d;
    @(negedge clk);
    cs = 1'b0; writemem = 1'b0;
  endtask

  task automatic bus_rd(input int a, output logic [7:0] d);
    cs = 1'b1; readmem = 1'b1; writemem = 1'b0;
    address = ADDR_W'(a);
    #1 d = dataOut;
    @(negedge clk);
    cs = 1'b0; readmem = 1'b0;
  endtask

  task automatic rd_head(output logic [31:0] v);
    logic [7:0] b;
    v = '0;
    for (int k = 0; k < FN_W/8; k++) begin
      bus_rd(8 + k, b);
      v[8*k +: 8] = b;
    end
  endtask

  task automatic wait_cnt(input int target, input string name);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < 400; i++) begin
      bus_rd(3, c);
      if (int'(c) >= target) break;
    end
    check(name, int'(c) >= target, 1);
  endtask

  // Reference: N! mod 2^FN_W; overflow iff the exact factorial leaves FN_W bits.
  function automatic logic [31:0] model_fact(input int n, output bit ovf);
    longint unsigned acc;
    acc = 1;
    ovf = 1'b0;
    for (int i = 2; i <= n; i++) begin
      if (!ovf && (acc * longint'(i)) >= (64'd1 << FN_W)) ovf = 1'b1;
      acc = (acc * longint'(i)) & ((64'd1 << FN_W) - 1);
    end
    return acc[31:0];
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0]  r;
    logic [31:0] v;
    logic [31:0] mq[$];
    bit          mo[$];
    int          lat, n, k;
    bit          o;
    logic [31:0] seq_exp [3];

    tbl = '{'{0,  32'h0000_0001, 1'b0}, '{1,  32'h0000_0001, 1'b0},
            '{2,  32'h0000_0002, 1'b0}, '{5,  32'h0000_0078, 1'b0},
            '{7,  32'h0000_13B0, 1'b0}, '{8,  32'h0000_9D80, 1'b0},
            '{10, 32'h0037_5F00, 1'b0}, '{12, 32'h1C8C_FC00, 1'b0},
            '{13, 32'h7328_CC00, 1'b1}};

    // ---- reset state
    repeat (3) @(negedge clk);
    check("rst_mdr", memDataReady, 0);
    check("rst_irq", interrupt, 0);
    rst = 1'b1;
    @(negedge clk);
    bus_rd(2, r);       check("reset_status", r, 0);
    bus_rd(3, r);       check("reset_count", r, 0);
    bus_rd(1, r);       check("reset_ctrl", r, 0);
    bus_rd('h0C, r);    check("unmapped_rd", r, 0);

    // ---- memDataReady handshake
    @(negedge clk);
    check("mdr_idle", memDataReady, 0);
    bus_rd(2, r);
    check("mdr_pulse", memDataReady, 1);
    @(negedge clk);
    check("mdr_single", memDataReady, 0);
    bus_rd(2, r);
    check("mdr_b2b_1", memDataReady, 1);
    bus_rd(3, r);
    check("mdr_b2b_2", memDataReady, 1);
    @(negedge clk);
    check("mdr_b2b_end", memDataReady, 0);

    // ---- table: latency, value, overflow flag, pop
    for (int i = 0; i < 9; i++) begin
      bus_wr(0, 8'(tbl[i].n));
      lat = -1;
      for (int c = 0; c < 300; c++) begin
        bus_rd(2, r);
        if (r[0]) begin lat = c; break; end
      end
      check($sformatf("latency_n%0d", tbl[i].n), lat, ((tbl[i].n > 1) ? tbl[i].n : 1) + 2);
      // deselected read: bus must be released while a result is pending
      readmem = 1'b1; address = ADDR_W'(3);
      #1 check("hiz_no_cs", (dataOut === 8'hzz) || (dataOut === 8'h00), 1);
      @(negedge clk);
      readmem = 1'b0;
      check("mdr_no_cs", memDataReady, 0);
      rd_head(v);
      check($sformatf("result_n%0d", tbl[i].n), v, tbl[i].res);
      bus_rd(2, r);
      check($sformatf("ovf_n%0d", tbl[i].n), r[4], OVF_EN ? tbl[i].ovf : 1'b0);
      bus_wr(3, 8'h00);
      bus_rd(2, r);
      check($sformatf("idle_status_n%0d", tbl[i].n), r, 0);
    end

    // ---- queued jobs 0, 1, 12 popped in order
    seq_exp = '{32'h1, 32'h1, 32'h1C8C_FC00};
    bus_wr(0, 8'd0); bus_wr(0, 8'd1); bus_wr(0, 8'd12);
    wait_cnt(3, "seq_wait3");
    for (int i = 0; i < 3; i++) begin
      bus_rd(3, r);
      check("seq_count", r, 3 - i);
      rd_head(v);
      check("seq_value", v, seq_exp[i]);
      bus_wr(3, 8'h00);
    end
    bus_rd(3, r);       check("seq_count_end", r, 0);
    bus_wr(3, 8'h00);
    bus_rd(3, r);       check("pop_empty", r, 0);

    // ---- overfill: result queue full, five pushes, fifth dropped
    for (int i = 0; i < 4; i++) bus_wr(0, 8'd1);
    wait_cnt(4, "fill_wait4");
    for (int i = 0; i < 5; i++) bus_wr(0, 8'd2);
    bus_rd(2, r);
    check("ovr_err", r[3], 1);
    check("ovr_cmd_full", r[1], 1);
    check("ovr_busy", r[2], 1);
    check("ovr_irq_disabled", interrupt, 0);
    bus_wr(1, 8'h01);
    check("ovr_irq_enabled", interrupt, 1);
    bus_wr(1, 8'h05);
    bus_rd(2, r);
    check("err_cleared", r[3], 0);
    bus_rd(1, r);
    check("ctrl_after_clear", r, 8'h01);
    bus_wr(1, 8'h00);
    check("irq_off", interrupt, 0);
    for (int i = 0; i < 8; i++) begin
      wait_cnt(1, "drain_wait");
      rd_head(v);
      check("drain_value", v, (i < 4) ? 1 : 2);
      bus_wr(3, 8'h00);
    end
    repeat (30) @(negedge clk);
    bus_rd(3, r);       check("drop_never_appears", r, 0);

    // ---- randomized jobs against the reference model
    for (int round = 0; round < 15; round++) begin
      k = $urandom_range(1, 3);
      for (int j = 0; j < k; j++) begin
        n = $urandom_range(0, 20);
        bus_wr(0, 8'(n));
        mq.push_back(model_fact(n, o));
        mo.push_back(o);
      end
      for (int j = 0; j < k; j++) begin
        wait_cnt(1, "rand_wait");
        rd_head(v);
        check("rand_result", v, mq.pop_front());
        bus_rd(2, r);
        o = mo.pop_front();
        check("rand_ovf", r[4], OVF_EN && o);
        bus_wr(3, 8'h00);
      end
    end
    bus_rd(3, r);       check("rand_count_end", r, 0);

    // ---- flush during a long job
    bus_wr(1, 8'h01);
    bus_wr(0, 8'd10);
    repeat (4) @(negedge clk);
    bus_rd(2, r);       check("flush_busy_before", r[2], 1);
    bus_wr(1, 8'h03);
    bus_rd(2, r);       check("flush_status", r, 0);
    bus_rd(3, r);       check("flush_count", r, 0);
    repeat (20) @(negedge clk);
    bus_rd(3, r);       check("flush_no_result", r, 0);
    bus_rd(1, r);       check("flush_ctrl_kept", r, 8'h01);
    check("flush_irq", interrupt, 0);

    // ---- reset mid-job
    bus_wr(0, 8'd1);
    wait_cnt(1, "pre_rst_wait");
    check("pre_rst_irq", interrupt, 1);
    bus_wr(0, 8'd10);
    repeat (3) @(negedge clk);
    bus_rd(2, r);       check("pre_rst_busy", r[2], 1);
    #2 rst = 1'b0;
    #1;
    check("rst_async_mdr", memDataReady, 0);
    check("rst_async_irq", interrupt, 0);
    cs = 1'b1; readmem = 1'b1; address = ADDR_W'(2);
    #1 check("rst_async_status", dataOut, 0);
    cs = 1'b0; readmem = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    bus_rd(3, r);       check("post_rst_count", r, 0);
    bus_rd(2, r);       check("post_rst_status", r, 0);
    bus_rd(1, r);       check("post_rst_ctrl", r, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fact_accel_queued.md
FACT_ACCEL_QUEUED -- requirements
Module: fact_accel_queued

Interface
REQ-001 Parameter DATA_W, 8, bus data width in bits; the block SHALL support only 8.
REQ-002 Parameter ADDR_W, 12, bus address width.
REQ-003 Parameter N_W, 8, operand width.
REQ-004 Parameter FN_W, 32, result width; SHALL be a multiple of 8, 16..64.
REQ-005 Parameter DEPTH, 4, entries per queue; SHALL be a power of two, >=2.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-low.
REQ-008 cs  in  1  chip select.
REQ-009 readmem  in  1  read strobe.
REQ-010 writemem  in  1  write strobe.
REQ-011 address  in  ADDR_W  register offset.
REQ-012 dataIn  in  DATA_W  write data.
REQ-013 dataOut  out  DATA_W  read data; SHALL be high-Z unless cs&&readmem.
REQ-014 memDataReady  out  1  access acknowledge.
REQ-015 interrupt  out  1  level interrupt.

Function
REQ-016 Register map SHALL be: 0x00 W N-push; 0x01 RW CTRL{bit0 int_en, bit1 flush (self-clearing), bit2 err-clear (W1C)}; 0x02 R STATUS{bit0 res_valid, bit1 cmd_full, bit2 busy, bit3 err, bit4 ovf_head}; 0x03 R result count, W any value = pop result; 0x08+k R byte k of head result (k < FN_W/8); unmapped reads SHALL return 0.
REQ-017 A write to 0x00 SHALL push dataIn[N_W-1:0] into the command queue; if the queue is full at that edge the write SHALL be dropped and err set, even if the engine pops on the same edge.
REQ-018 memDataReady SHALL pulse high for exactly one cycle, one cycle after any edge where cs&&(readmem||writemem) is sampled; back-to-back accesses SHALL give one pulse per access cycle.
REQ-019 Engine FSM states SHALL be IDLE, MUL, STORE.
REQ-020 IDLE->MUL when the command queue is non-empty and the result queue is not full: pop, acc=1, cnt=N.
REQ-021 MUL: if cnt<=1 go to STORE; else acc=(acc*cnt) truncated to FN_W, cnt=cnt-1.
REQ-022 STORE: push acc (plus overflow flag) into the result queue, then go to IDLE.
REQ-023 Result valid latency SHALL be max(N,1)+2 edges after the push edge when the engine is idle and queues are empty; 0! = 1! = 1.
REQ-024 busy SHALL be 1 whenever the state is not IDLE or the command queue is non-empty.
REQ-025 Result pop on an empty queue SHALL be ignored; a simultaneous engine push and processor pop SHALL leave the count unchanged.
REQ-026 flush SHALL empty both queues and force the FSM to IDLE on the same edge, discarding any in-flight result; err and int_en SHALL be unchanged.
REQ-027 interrupt SHALL equal int_en && (res_valid || err), combinationally from registered state.

Reset
REQ-028 rst low SHALL immediately clear: both queues, FSM to IDLE, acc, cnt, int_en, err, memDataReady; interrupt SHALL read 0; reset mid-computation SHALL discard the work.

Configuration
REQ-029 With FACT_OVF_DETECT_EN defined, the overflow flag SHALL be tracked: set if any MUL product exceeds FN_W bits, sticky per job, stored with the result, and reported in STATUS bit4 for the head entry.
REQ-030 Without FACT_OVF_DETECT_EN, no overflow storage SHALL exist and STATUS bit4 SHALL read 0; results remain truncated.

Structure
REQ-031 Shared package fact_accel_pkg SHALL hold the register offsets, CTRL/STATUS bit positions, and the FSM state typedef.
REQ-032 One sub-module fact_fifo (parametrised width/depth, synchronous, full/empty/count) SHALL be instantiated twice: command (N_W) and result (FN_W or FN_W+1).

Verification
REQ-033 Write N=5 to 0x00 -> STATUS bit0 rises 7 edges later; bytes 0x08..0x0B read 0x78,0,0,0.
REQ-034 Push N=0, 1, 12 then pop sequentially -> 1, 1, 0x1C8CFC00 in order; count 3->2->1->0.
REQ-035 With FACT_OVF_DETECT_EN, N=13 -> result 0x7328CC00 (truncated), STATUS bit4=1; N=12 -> bit4=0.
REQ-036 5 pushes with DEPTH=4 while result queue full -> 5th dropped, err=1, interrupt=1 when int_en=1; write CTRL bit2 -> err=0.
REQ-037 flush during N=10 MUL -> busy=0 and count=0 next cycle, no result appears; rst low mid-job -> all outputs at reset values.
REQ-038 Read 0x02 with cs=1 -> memDataReady single-cycle pulse one cycle later; cs=0 -> dataOut high-Z, no pulse.
